memory_checker: RTL and testbench

Simulation-only RAM model that sits on the processor memory bus at a fixed base address and verifies its own contents against a parametrised expected image. The check is run on demand by a start/busy/done handshake: a scan FSM compares one word per cycle under a per-bit care mask and reports pass/fail, the first mismatching index and a saturating write count. Testbenches instantiate one per checked region and sample the result at end of program.

---
 rtl/memory_checker_pkg.sv | 7 +
 rtl/memory_checker_if.sv | 27 ++
 rtl/memory_checker_mem.sv | 45 ++++
 rtl/memory_checker.sv | 84 ++++++++
 tb/tb_memory_checker.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/memory_checker_pkg.sv
// memory_checker_pkg: scan FSM state type and index-width helper shared by the memory checker files
package memory_checker_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/memory_checker_if.sv
// memory_checker_if: processor bus port plus check handshake and result signals
interface memory_checker_if import memory_checker_pkg::*; #(
  parameter int addr_size = 16,
  parameter int word_size = 16,
  parameter int array_size = 4
);
  localparam int IW = idx_w(array_size);
  logic [addr_size-1:0] addr_i;
  logic [word_size-1:0] data_i;
  logic write_en_i;
  logic [word_size-1:0] data_o;
  logic check_start_i;
  logic check_busy_o;
  logic check_done_o;
  logic content_ok_o;
  logic mismatch_valid_o;
  logic [IW-1:0] mismatch_idx_o;
  logic [15:0] write_count_o;
  modport master(
    output addr_i, data_i, write_en_i, check_start_i,
    input data_o, check_busy_o, check_done_o, content_ok_o, mismatch_valid_o, mismatch_idx_o, write_count_o
  );
  modport slave(
    input addr_i, data_i, write_en_i, check_start_i,
    output data_o, check_busy_o, check_done_o, content_ok_o, mismatch_valid_o, mismatch_idx_o, write_count_o
  );
endinterface

// File: rtl/memory_checker_mem.sv
// memory_checker_mem: word storage with address decode, registered read port and reset image load
module memory_checker_mem import memory_checker_pkg::*; #(
  parameter int base_addr = 0,
  parameter int addr_size = 16,
  parameter int word_size = 16,
  parameter int array_size = 4,
  parameter logic [array_size*word_size-1:0] array_content = '1,
  parameter bit init_zero = 1'b0,
  localparam int IW = idx_w(array_size)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [addr_size-1:0] addr_i,
  input  logic [word_size-1:0] data_i,
  input  logic                 write_en_i,
  input  logic [IW-1:0]        scan_idx_i,
  output logic [word_size-1:0] data_o,
  output logic [word_size-1:0] scan_word_o,
  output logic                 wr_hit_o
);
  localparam logic [addr_size-1:0] BASE = addr_size'(base_addr);
  localparam logic [addr_size-1:0] SIZE = addr_size'(array_size);
  logic [word_size-1:0] mem_q [array_size];
  logic [word_size-1:0] data_q;
  logic [addr_size-1:0] off;
  logic [IW-1:0] idx;
  logic hit;
  assign off = addr_i - BASE;
  assign hit = addr_i >= BASE && off < SIZE;
  assign idx = off[IW-1:0];
  assign wr_hit_o = write_en_i && hit;
  assign scan_word_o = mem_q[scan_idx_i];
  assign data_o = data_q;
  // the inverted image makes a never-written region fail its first scan
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
      for (int i = 0; i < array_size; i++)
        mem_q[i] <= init_zero ? '0 : ~array_content[i*word_size +: word_size];
    end else begin
      data_q <= hit ? mem_q[idx] : '0;
      if (wr_hit_o) mem_q[idx] <= data_i;
    end
  end
endmodule

// File: rtl/memory_checker.sv
// memory_checker: bus RAM model whose contents are scanned against an expected image on request
module memory_checker import memory_checker_pkg::*; #(
  parameter int base_addr = 0,
  parameter int addr_size = 16,
  parameter int word_size = 16,
  parameter int array_size = 4,
  parameter logic [array_size*word_size-1:0] array_content = '1,
  parameter logic [array_size*word_size-1:0] care_mask = '1,
  parameter bit init_zero = 1'b0
) (
  input logic clk,
  input logic reset,
  memory_checker_if.slave bus
);
  localparam int IW = idx_w(array_size);
  localparam logic [IW-1:0] LAST = IW'(array_size - 1);
  state_e state_q;
  logic [IW-1:0] scan_idx_q, pend_q, midx_q;
  logic fail_q, busy_q, done_q, ok_q, mv_q;
  logic [15:0] wc_q, wc_d;
  logic [word_size-1:0] scan_word, exp_w, mask_w;
  logic wr_hit, bad;
  memory_checker_mem #(
    .base_addr(base_addr), .addr_size(addr_size), .word_size(word_size),
    .array_size(array_size), .array_content(array_content), .init_zero(init_zero)
  ) u_mem (
    .clk(clk), .reset(reset), .addr_i(bus.addr_i), .data_i(bus.data_i),
    .write_en_i(bus.write_en_i), .scan_idx_i(scan_idx_q), .data_o(bus.data_o),
    .scan_word_o(scan_word), .wr_hit_o(wr_hit)
  );
  assign exp_w = array_content[scan_idx_q*word_size +: word_size];
  assign mask_w = care_mask[scan_idx_q*word_size +: word_size];
  assign bad = |((scan_word ^ exp_w) & mask_w);
  assign wc_d = wr_hit && wc_q != 16'hFFFF ? wc_q + 16'd1 : wc_q;
  assign bus.check_busy_o = busy_q;
  assign bus.check_done_o = done_q;
  assign bus.content_ok_o = ok_q;
  assign bus.mismatch_valid_o = mv_q;
  assign bus.mismatch_idx_o = midx_q;
  assign bus.write_count_o = wc_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      scan_idx_q <= '0;
      pend_q <= '0;
      fail_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ok_q <= 1'b0;
      mv_q <= 1'b0;
      midx_q <= '0;
      wc_q <= '0;
    end else begin
      wc_q <= wc_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.check_start_i) begin
          state_q <= SCAN;
          busy_q <= 1'b1;
          scan_idx_q <= '0;
          fail_q <= 1'b0;
          pend_q <= '0;
        end
        SCAN: begin
          if (bad && !fail_q) begin
            fail_q <= 1'b1;
            pend_q <= scan_idx_q;
          end
          if (scan_idx_q == LAST) state_q <= DONE;
          else scan_idx_q <= scan_idx_q + IW'(1);
        end
        DONE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          ok_q <= !fail_q;
          mv_q <= fail_q;
          midx_q <= pend_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_checker.sv
// tb_memory_checker: three checkers on one shared bus compared every cycle against a behavioural model
module tb_memory_checker;
  localparam logic [63:0] C0 = 64'h0004_0003_0002_0001;
  localparam logic [47:0] C1 = 48'h12FF_BEEF_0001;
  localparam logic [47:0] M1 = 48'h00FF_FFFF_FFFF;
  localparam logic [47:0] M2 = 48'hFFFF_FFFF_FFFF;
  logic clk = 1'b0, reset;
  logic [15:0] addr, din;
  logic we, start;
  int tests = 0, fails = 0;
  bit armed = 1'b0;
  int m_size [3], m_base [3], m_ph [3], m_pend [3], m_wc [3];
  bit m_iz [3], m_fail [3], m_done [3], m_ok [3], m_mv [3];
  logic [15:0] m_exp [3][4], m_mask [3][4], m_mem [3][4], m_rd [3];
  logic [1:0] m_midx [3];
  int off;
  bit hit;
  always #5 clk = ~clk;
  memory_checker_if #(.addr_size(16), .word_size(16), .array_size(4)) if0 ();
  memory_checker_if #(.addr_size(16), .word_size(16), .array_size(3)) if1 ();
  memory_checker_if #(.addr_size(16), .word_size(16), .array_size(3)) if2 ();
  assign {if0.addr_i, if0.data_i, if0.write_en_i, if0.check_start_i} = {addr, din, we, start};
  assign {if1.addr_i, if1.data_i, if1.write_en_i, if1.check_start_i} = {addr, din, we, start};
  assign {if2.addr_i, if2.data_i, if2.write_en_i, if2.check_start_i} = {addr, din, we, start};
  memory_checker #(.base_addr(8), .addr_size(16), .word_size(16), .array_size(4),
    .array_content(C0), .care_mask('1), .init_zero(1'b0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  memory_checker #(.base_addr(0), .addr_size(16), .word_size(16), .array_size(3),
    .array_content(C1), .care_mask(M1), .init_zero(1'b1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  memory_checker #(.base_addr(0), .addr_size(16), .word_size(16), .array_size(3),
    .array_content(C1), .care_mask(M2), .init_zero(1'b1)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  initial begin
    m_size = '{4, 3, 3};
    m_base = '{8, 0, 0};
    m_iz = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      m_exp[0][i] = C0[i*16 +: 16];
      m_mask[0][i] = 16'hFFFF;
      m_exp[1][i] = i < 3 ? C1[i*16 +: 16] : 16'h0;
      m_exp[2][i] = m_exp[1][i];
      m_mask[1][i] = i < 3 ? M1[i*16 +: 16] : 16'h0;
      m_mask[2][i] = i < 3 ? M2[i*16 +: 16] : 16'h0;
    end
  end
  // scan progress is tracked as edges elapsed since the accepted start
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        for (int j = 0; j < 4; j++) m_mem[k][j] = m_iz[k] ? 16'h0 : ~m_exp[k][j];
        m_rd[k] = 0; m_wc[k] = 0; m_ph[k] = -1; m_fail[k] = 0; m_pend[k] = 0;
        m_done[k] = 0; m_ok[k] = 0; m_mv[k] = 0; m_midx[k] = 0;
      end else begin
        m_done[k] = 0;
        if (m_ph[k] < 0) begin
          if (start) begin m_ph[k] = 0; m_fail[k] = 0; m_pend[k] = 0; end
        end else begin
          m_ph[k]++;
          if (m_ph[k] <= m_size[k]) begin
            if (((m_mem[k][m_ph[k]-1] ^ m_exp[k][m_ph[k]-1]) & m_mask[k][m_ph[k]-1]) != 0 && !m_fail[k]) begin
              m_fail[k] = 1; m_pend[k] = m_ph[k] - 1;
            end
          end else begin
            m_ok[k] = !m_fail[k]; m_mv[k] = m_fail[k]; m_midx[k] = 2'(m_pend[k]);
            m_done[k] = 1; m_ph[k] = -1;
          end
        end
        off = int'(addr) - m_base[k];
        hit = off >= 0 && off < m_size[k];
        m_rd[k] = 16'h0;
        if (hit) m_rd[k] = m_mem[k][off];
        if (we && hit) begin
          m_mem[k][off] = din;
          if (m_wc[k] < 65535) m_wc[k]++;
        end
      end
    end
    armed = 1'b1;
  end
  task automatic cmp(input int k, input logic [15:0] d, input logic b, dn, ok, mv,
                     input logic [1:0] mi, input logic [15:0] wc);
    tests++;
    if (d !== m_rd[k] || b !== (m_ph[k] >= 0) || dn !== m_done[k] || ok !== m_ok[k] ||
        mv !== m_mv[k] || mi !== m_midx[k] || wc !== 16'(m_wc[k])) begin
      fails++;
      $display("FAIL model_u%0d t=%0t got/exp: data %h/%h busy %b/%b done %b/%b ok %b/%b mv %b/%b idx %0d/%0d wc %0d/%0d",
        k, $time, d, m_rd[k], b, m_ph[k] >= 0, dn, m_done[k], ok, m_ok[k], mv, m_mv[k], mi, m_midx[k], wc, m_wc[k]);
    end
  endtask
  always @(negedge clk) if (armed) begin
    cmp(0, if0.data_o, if0.check_busy_o, if0.check_done_o, if0.content_ok_o, if0.mismatch_valid_o, if0.mismatch_idx_o, if0.write_count_o);
    cmp(1, if1.data_o, if1.check_busy_o, if1.check_done_o, if1.content_ok_o, if1.mismatch_valid_o, if1.mismatch_idx_o, if1.write_count_o);
    cmp(2, if2.data_o, if2.check_busy_o, if2.check_done_o, if2.content_ok_o, if2.mismatch_valid_o, if2.mismatch_idx_o, if2.write_count_o);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; din = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask
  task automatic wait_done(input bit hold, output int nb);
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (if0.check_busy_o) nb++;
      if (if0.check_done_o) return;
    end
    tests++; fails++;
    $display("FAIL scan_timeout: got no check_done, expected one within 30 cycles");
  endtask
  int nb;
  initial begin
    reset = 1'b0; addr = 0; din = 0; we = 0; start = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(if0.check_busy_o), 0);
    chk("rst_ok", 32'(if0.content_ok_o), 0);
    chk("rst_wc", 32'(if0.write_count_o), 0);
    reset = 1'b1;
    start = 1'b1; wait_done(1'b0, nb);
    chk("scan1_busy_cycles", nb, 5);
    chk("scan1_ok", 32'(if0.content_ok_o), 0);
    chk("scan1_mv", 32'(if0.mismatch_valid_o), 1);
    chk("scan1_idx", 32'(if0.mismatch_idx_o), 0);
    wr(0, 16'h0001); wr(1, 16'hBEEF); wr(2, 16'h00FF);
    wr(8, 1); wr(9, 2); wr(10, 3); wr(11, 4); wr(12, 16'hFFFF); wr(7, 16'hFFFF);
    addr = 10; @(negedge clk);
    chk("read_base2", 32'(if0.data_o), 3);
    addr = 12; @(negedge clk);
    chk("read_base4", 32'(if0.data_o), 0);
    addr = 7; @(negedge clk);
    chk("read_base_m1", 32'(if0.data_o), 0);
    addr = 2; @(negedge clk);
    chk("read_u1_w2", 32'(if1.data_o), 32'h00FF);
    chk("wc_u0", 32'(if0.write_count_o), 4);
    chk("wc_u1", 32'(if1.write_count_o), 3);
    start = 1'b1; wait_done(1'b0, nb);
    chk("scan2_ok", 32'(if0.content_ok_o), 1);
    chk("scan2_mv", 32'(if0.mismatch_valid_o), 0);
    chk("masked_ok", 32'(if1.content_ok_o), 1);
    chk("unmasked_ok", 32'(if2.content_ok_o), 0);
    chk("unmasked_idx", 32'(if2.mismatch_idx_o), 2);
    start = 1'b1; wait_done(1'b1, nb);
    @(negedge clk);
    chk("held_restart_busy", 32'(if0.check_busy_o), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(if0.check_busy_o), 0);
    chk("abort_done", 32'(if0.check_done_o), 0);
    chk("abort_wc", 32'(if0.write_count_o), 0);
    chk("abort_mv_u2", 32'(if2.mismatch_valid_o), 0);
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wr(8, 1); wr(9, 2); wr(10, 3); wr(11, 4);
    wait_done(1'b0, nb);
    chk("same_cycle_ok", 32'(if0.content_ok_o), 0);
    chk("same_cycle_idx", 32'(if0.mismatch_idx_o), 0);
    start = 1'b1; wait_done(1'b0, nb);
    chk("rescan_ok", 32'(if0.content_ok_o), 1);
    chk("rescan_wc", 32'(if0.write_count_o), 4);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, expected finish before 200000");
    $fatal(1);
  end
endmodule
